// File: rtl/xdn_pkg.sv
// rtl/xdn_pkg.sv - shared opcodes, step encoding and control-word layout for the sequencer
package xdn_pkg;

  localparam int MAX_STEPS_DEF = 5;

  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int T4 = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic {ST_RUN, ST_HALT} seq_state_t;

  // Every field is active-high here; the top level applies the bus polarities.
  typedef struct packed {
    logic pc_count_enable;
    logic pc_write_bus;
    logic pc_jump;
    logic mar_read_bus;
    logic ram_read_bus;
    logic ram_write_bus;
    logic ir_read_bus;
    logic ir_write_bus;
    logic a_read_bus;
    logic a_write_bus;
    logic b_read_bus;
    logic alu_write_bus;
    logic alu_subtract;
    logic flags_update;
    logic out_read_bus;
  } ctrl_word_t;

  // Last T-state an opcode occupies; everything not listed finishes after T2.
  function automatic int unsigned end_step(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA: end_step = T3;
      OP_ADD, OP_SUB: end_step = T4;
      default:        end_step = T2;
    endcase
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// rtl/microcode_rom.sv - combinational (opcode, step, flags) to control-word table
module microcode_rom
  import xdn_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [STEP_WIDTH-1:0]   step,
  input  logic                    zero_flag,
  input  logic                    carry_flag,
  output ctrl_word_t              ctrl,
  output logic                    last_step,
  output logic                    halt_req
);

  logic [OPCODE_WIDTH+3:0] op_ext;
  logic [3:0]              op;
  logic [31:0]             step_i;

  // Opcodes wider than four bits with any upper bit set are undefined and run as NOP.
  assign op_ext    = {4'b0000, opcode};
  assign op        = (|(op_ext >> 4)) ? OP_NOP : op_ext[3:0];
  assign step_i    = 32'(step);
  assign last_step = (step_i >= end_step(op));
  assign halt_req  = (step_i == T2) && (op == OP_HLT);

  always_comb begin
    ctrl = '0;
    case (step_i)
      T0: begin
        ctrl.pc_write_bus = 1'b1;
        ctrl.mar_read_bus = 1'b1;
      end
      T1: begin
        ctrl.ram_write_bus   = 1'b1;
        ctrl.ir_read_bus     = 1'b1;
        ctrl.pc_count_enable = 1'b1;
      end
      T2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl.ir_write_bus = 1'b1;
            ctrl.mar_read_bus = 1'b1;
          end
          OP_LDI: begin
            ctrl.ir_write_bus = 1'b1;
            ctrl.a_read_bus   = 1'b1;
          end
          OP_JMP: begin
            ctrl.ir_write_bus = 1'b1;
            ctrl.pc_jump      = 1'b1;
          end
          OP_JC: begin
            ctrl.ir_write_bus = carry_flag;
            ctrl.pc_jump      = carry_flag;
          end
          OP_JZ: begin
            ctrl.ir_write_bus = zero_flag;
            ctrl.pc_jump      = zero_flag;
          end
          OP_OUT: begin
            ctrl.a_write_bus  = 1'b1;
            ctrl.out_read_bus = 1'b1;
          end
          default: ;
        endcase
      end
      T3: begin
        case (op)
          OP_LDA: begin
            ctrl.ram_write_bus = 1'b1;
            ctrl.a_read_bus    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.ram_write_bus = 1'b1;
            ctrl.b_read_bus    = 1'b1;
          end
          OP_STA: begin
            ctrl.a_write_bus  = 1'b1;
            ctrl.ram_read_bus = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        if (op == OP_ADD || op == OP_SUB) begin
          ctrl.alu_write_bus = 1'b1;
          ctrl.a_read_bus    = 1'b1;
          ctrl.flags_update  = 1'b1;
          ctrl.alu_subtract  = (op == OP_SUB);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - RUN/HALT FSM and T-state counter driving the microcode table
module control_sequencer
  import xdn_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int MAX_STEPS    = MAX_STEPS_DEF
) (
  input  logic                         i_CLOCK,
  input  logic                         i_CLEAR,
  input  logic [OPCODE_WIDTH-1:0]      i_IR_DATA,
  input  logic                         i_ZERO_FLAG,
  input  logic                         i_CARRY_FLAG,
  output logic                         o_PC_COUNT_ENABLE,
  output logic                         o_PC_WRITE_BUS_n,
  output logic                         o_PC_JUMP_n,
  output logic                         o_MAR_READ_BUS_n,
  output logic                         o_RAM_READ_BUS,
  output logic                         o_RAM_WRITE_BUS_n,
  output logic                         o_IR_READ_BUS_n,
  output logic                         o_IR_WRITE_BUS_n,
  output logic                         o_A_READ_BUS_n,
  output logic                         o_A_WRITE_BUS_n,
  output logic                         o_B_READ_BUS_n,
  output logic                         o_ALU_WRITE_BUS_n,
  output logic                         o_ALU_SUBTRACT,
  output logic                         o_FLAGS_UPDATE_n,
  output logic                         o_OUT_READ_BUS,
  output logic                         o_HALT,
  output logic [$clog2(MAX_STEPS)-1:0] o_STEP
);

  localparam int STEP_WIDTH = $clog2(MAX_STEPS);

  seq_state_t            state_q, state_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  ctrl_word_t            rom_ctrl, ctrl;
  logic                  rom_last, rom_halt;

  microcode_rom #(
    .OPCODE_WIDTH(OPCODE_WIDTH),
    .STEP_WIDTH  (STEP_WIDTH)
  ) u_rom (
    .opcode    (i_IR_DATA),
    .step      (step_q),
    .zero_flag (i_ZERO_FLAG),
    .carry_flag(i_CARRY_FLAG),
    .ctrl      (rom_ctrl),
    .last_step (rom_last),
    .halt_req  (rom_halt)
  );

  always_ff @(posedge i_CLOCK or posedge i_CLEAR) begin
    if (i_CLEAR) begin
      state_q <= ST_RUN;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ctrl    = '0;
    case (state_q)
      ST_RUN: begin
        // Clear gates the controls directly so they drop without waiting for an edge.
        if (!i_CLEAR) ctrl = rom_ctrl;
        if (rom_halt) begin
          state_d = ST_HALT;
          step_d  = '0;
        end else if (rom_last || step_q == STEP_WIDTH'(MAX_STEPS - 1)) begin
          step_d = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      ST_HALT: step_d = '0;
      default: begin
        state_d = ST_RUN;
        step_d  = '0;
      end
    endcase
  end

  assign o_PC_COUNT_ENABLE = ctrl.pc_count_enable;
  assign o_PC_WRITE_BUS_n  = ~ctrl.pc_write_bus;
  assign o_PC_JUMP_n       = ~ctrl.pc_jump;
  assign o_MAR_READ_BUS_n  = ~ctrl.mar_read_bus;
  assign o_RAM_READ_BUS    = ctrl.ram_read_bus;
  assign o_RAM_WRITE_BUS_n = ~ctrl.ram_write_bus;
  assign o_IR_READ_BUS_n   = ~ctrl.ir_read_bus;
  assign o_IR_WRITE_BUS_n  = ~ctrl.ir_write_bus;
  assign o_A_READ_BUS_n    = ~ctrl.a_read_bus;
  assign o_A_WRITE_BUS_n   = ~ctrl.a_write_bus;
  assign o_B_READ_BUS_n    = ~ctrl.b_read_bus;
  assign o_ALU_WRITE_BUS_n = ~ctrl.alu_write_bus;
  assign o_ALU_SUBTRACT    = ctrl.alu_subtract;
  assign o_FLAGS_UPDATE_n  = ~ctrl.flags_update;
  assign o_OUT_READ_BUS    = ctrl.out_read_bus;
  assign o_HALT            = (state_q == ST_HALT);
  assign o_STEP            = step_q;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 4, the opcode field width taken from the instruction register.
REQ-002 SHALL have parameter MAX_STEPS, default 5, the number of T-states per instruction (T0..T(MAX_STEPS-1)); minimum 5.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports:
- i_CLOCK, in, 1: CPU clock; all state changes on the rising edge.
- i_CLEAR, in, 1: asynchronous active-high reset.
- i_IR_DATA, in, OPCODE_WIDTH: current opcode.
- i_ZERO_FLAG, in, 1: ALU zero flag.
- i_CARRY_FLAG, in, 1: ALU carry flag.
- o_PC_COUNT_ENABLE, out, 1: high to increment PC.
- o_PC_WRITE_BUS_n, out, 1: low to make PC drive the bus.
- o_PC_JUMP_n, out, 1: low to make PC load from the bus.
- o_MAR_READ_BUS_n, out, 1: low to make MAR load from the bus.
- o_RAM_READ_BUS, out, 1: high to store the bus into RAM.
- o_RAM_WRITE_BUS_n, out, 1: low to make RAM drive the bus.
- o_IR_READ_BUS_n, out, 1: low to make IR load from the bus.
- o_IR_WRITE_BUS_n, out, 1: low to make the IR operand drive the bus.
- o_A_READ_BUS_n, out, 1: A register load.
- o_A_WRITE_BUS_n, out, 1: A register drive.
- o_B_READ_BUS_n, out, 1: B register load.
- o_ALU_WRITE_BUS_n, out, 1: ALU result drive.
- o_ALU_SUBTRACT, out, 1: high selects subtract.
- o_FLAGS_UPDATE_n, out, 1: low to latch ALU flags.
- o_OUT_READ_BUS, out, 1: high to make the output register load.
- o_HALT, out, 1: high while halted.
- o_STEP, out, clog2(MAX_STEPS): current T-state.

Function
REQ-005 SHALL have two FSM states, RUN and HALT, plus a step counter that advances once per i_CLOCK rise in RUN.
REQ-006 SHALL decode every control output combinationally from (step, opcode, flags). Any signal not listed for a step is inactive: _n outputs high, others low.
REQ-007 T0 (all opcodes) SHALL assert PC_WRITE_BUS_n=0 and MAR_READ_BUS_n=0.
REQ-008 T1 SHALL assert RAM_WRITE_BUS_n=0, IR_READ_BUS_n=0 and PC_COUNT_ENABLE=1.
REQ-009 Execute steps SHALL be, by opcode:
- LDA 0x1: T2 IR_W+MAR_R; T3 RAM_W+A_R.
- ADD 0x2: T2 IR_W+MAR_R; T3 RAM_W+B_R; T4 ALU_W+A_R+FLAGS_UPDATE.
- SUB 0x3: as ADD, plus ALU_SUBTRACT=1 in T4.
- STA 0x4: T2 IR_W+MAR_R; T3 A_W+RAM_READ_BUS.
- LDI 0x5: T2 IR_W+A_R.
- JMP 0x6: T2 IR_W+PC_JUMP.
- JC 0x7: T2 IR_W+PC_JUMP only if i_CARRY_FLAG=1.
- JZ 0x8: T2 IR_W+PC_JUMP only if i_ZERO_FLAG=1.
- OUT 0xE: T2 A_W+OUT_READ_BUS.
- HLT 0xF: T2 no controls.
REQ-010 Early termination: the step counter SHALL return to 0 on the edge ending an opcode's last listed step. NOP 0x0, undefined opcodes and not-taken JC/JZ SHALL end after T2 with no execute controls.
REQ-011 The step counter SHALL also wrap to 0 unconditionally after T(MAX_STEPS-1).
REQ-012 Flags SHALL be sampled only during T2 of JC/JZ; flag changes in other steps have no effect.
REQ-013 On the edge ending HLT T2, the FSM SHALL enter HALT with o_HALT=1 and step=0. All controls are inactive in HALT. HALT is left only via i_CLEAR.
REQ-014 ALU_SUBTRACT SHALL be low in every step except SUB T4.

Reset
REQ-015 While i_CLEAR=1, the FSM SHALL be forced to RUN, step to 0, o_HALT to 0, and every control output to inactive, regardless of clock.
REQ-016 On the first rising edge after i_CLEAR falls, the sequencer SHALL be at T0 with fetch controls active. Reset mid-instruction SHALL abandon the instruction with no partial controls.

Structure
REQ-017 Opcode values, MAX_STEPS default and the step encoding SHALL live in a shared package xdn_pkg used by the top level and the bench.
REQ-018 The (opcode, step, flags) → control-word table SHALL be one sub-module, microcode_rom, purely combinational; control_sequencer holds the FSM and step counter.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset then LDA 0x1: steps 0,1,2,3,0. T3 has RAM_WRITE_BUS_n=0 and A_READ_BUS_n=0.
- SUB 0x3: five steps. T4 has ALU_SUBTRACT=1 and FLAGS_UPDATE_n=0; ALU_SUBTRACT=0 in T0–T3.
- JC with i_CARRY_FLAG=0, then JC with 1: first gives PC_JUMP_n=1 and step 0 after T2; second gives PC_JUMP_n=0 in T2.
- HLT 0xF: o_HALT=1 after T2; 10 further clocks show step=0 and all controls inactive. i_CLEAR pulse gives o_HALT=0 and T0.
- i_CLEAR asserted asynchronously in ADD T3: outputs go inactive immediately. After release, execution restarts at T0.
- Opcode 0xA (undefined): steps 0,1,2,0 with no execute controls.
